alu_seq_mdu: RTL and testbench
==============================

# alu_seq_mdu

Parametrised, multi-cycle successor to the 64-bit ripple ALU: the same AND/OR/ADD/SUB/SLT/NOR operation codes and Zero/Overflow flags, generalised to `WIDTH` bits. It adds iterative unsigned multiply, divide and remainder, and wraps everything in valid/ready handshakes on both sides with a registered result. It sits in the execute stage of the RISC-V datapath; the control unit stalls the pipeline while `in_ready` is low.

## Interface
Parameters:
- `WIDTH`, 64: operand/result width; even, ≥ 8.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  operands and opcode present.
- `in_ready`  out  1  block can accept a request this cycle.
- `A`, `B`  in  WIDTH each  operands, signed for SLT and overflow.
- `Operation`  in  4  opcode, see Operation.
- `out_valid`  out  1  result registers hold a completed result.
- `out_ready`  in  1  consumer takes the result.
- `Result`  out  WIDTH  registered result.
- `Overflow`  out  1  signed overflow, ADD/SUB only.
- `Zero`  out  1  high when `Result == 0`.

## Operation
- Opcodes:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR. These are single-cycle ops.
  - 1000 MUL: low WIDTH bits of the unsigned product.
  - 1001 DIVU: unsigned quotient.
  - 1010 REMU: unsigned remainder.
  - Any other code: Result 0, single-cycle.
- FSM states: IDLE, MUL, DIV, DONE. Reset state is IDLE.
  - IDLE: on `in_valid`, latch A, B and Operation.
    - Single-cycle op: go to DONE with the result.
    - MUL: go to MUL and clear the counter.
    - DIVU/REMU with B ≠ 0: go to DIV.
    - DIVU/REMU with B == 0: go straight to DONE. DIVU returns all ones; REMU returns A.
  - MUL: shift-add, one multiplier bit per cycle, LSB first, product truncated to WIDTH. Go to DONE after WIDTH iterations.
  - DIV: restoring division, one quotient bit per cycle, MSB first. Go to DONE after WIDTH iterations.
  - DONE: `out_valid` = 1 and Result/flags are held stable.
    - On `out_ready`: go to IDLE, or accept a new request in the same cycle (see handshake).
- Handshake:
  - `in_ready` = (state == IDLE) | (state == DONE & `out_ready`).
  - A transfer occurs when `in_valid & in_ready`.
  - Inputs are sampled only on a transfer; A, B and Operation may change freely at any other time.
  - The result is consumed when `out_valid & out_ready`.
  - If a new request is accepted in the same cycle as a result is consumed, the old result leaves and the new operation starts. No bubble for single-cycle ops.
- Arithmetic:
  - SUB is A + ~B + 1.
  - Overflow = carry into MSB XOR carry out of MSB, for ADD/SUB. It is 0 for every other op.
  - SLT result = {0…, sign of (A−B) XOR overflow}, i.e. signed A < B.
  - Zero is computed from the registered Result.
- Reset, asynchronous, at any time including mid-iteration:
  - State → IDLE.
  - `out_valid` = 0, `Result` = 0, `Overflow` = 0, `Zero` = 1, iteration counter = 0.
  - Any partial result is discarded.

## Timing
- Single-cycle ops: accepted at edge N; `out_valid` is high after edge N+1.
- MUL and DIVU/REMU with B ≠ 0: `out_valid` is high after edge N+1+WIDTH, i.e. 65 cycles for the default width.
- Divide by zero: same latency as a single-cycle op.
- `out_valid` stays high until consumed; Result/Overflow/Zero do not change while `out_valid & !out_ready`.
- `in_ready` is low throughout MUL and DIV. `in_valid` asserted during that time is ignored (no transfer occurs).
- Iteration counter is ⌈log2(WIDTH+1)⌉ bits wide and does not wrap.

## Structure
- Package `alu_pkg`:
  - Opcode localparams (OP_AND … OP_REMU).
  - FSM state enum.
  - Function `is_multicycle(op)`.
- Sub-module `alu_iter_unit`: holds the shared MUL/DIV datapath (accumulator/remainder register, shift register, counter) with a start/done interface.
- The top level holds the handshake FSM, the single-cycle ALU logic and the output registers.

## Test plan
All scenarios use WIDTH = 64 unless stated.
1. Reset mid-DIV at cycle 30 → immediately `out_valid` = 0, Result = 0, Zero = 1, `in_ready` = 1; the next ADD 5+7 gives Result = 12 one cycle after acceptance.
2. ADD 0x7FFF…FFFF + 1 → Result 0x8000…0000, Overflow = 1. SUB 5−5 → Result 0, Zero = 1. SLT −1 vs 1 → Result 1.
3. MUL 0xFFFF_FFFF × 0xFFFF_FFFF → Result 0xFFFF_FFFE_0000_0001, `out_valid` exactly 65 cycles after acceptance. MUL −1 × 2 → 0xFFFF…FFFE.
4. DIVU 100/7 → 14 and REMU 100/7 → 2, each after 65 cycles. DIVU 9/0 → all ones and REMU 9/0 → 9, each after 1 cycle.
5. Back-to-back: `out_ready` held at 1 with a stream of 8 ADDs → one result per cycle. Then `out_ready` = 0 for 5 cycles → Result held stable, `in_ready` = 0.
6. WIDTH = 8: MUL 15×17 → 0xFF after 9 cycles; DIVU 255/16 → 15; ADD 0x7F+1 → Overflow = 1.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Opcodes, FSM state type and helpers shared by alu_seq_mdu.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_MUL  = 4'b1000;
  localparam logic [3:0] OP_DIVU = 4'b1001;
  localparam logic [3:0] OP_REMU = 4'b1010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic is_multicycle(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_iter_unit.sv
`default_nettype none
// ============================================================================
// Module      : alu_iter_unit
// Description : Shared iterative datapath: shift-add multiply (LSB first) and
//               restoring divide (MSB first), one bit per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_iter_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             div_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] acc_next,
  output logic [WIDTH-1:0] sh_next
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] C_MAX  = CW'(WIDTH);

  // r_acc: product accumulator or partial remainder
  // r_sh : multiplier (shifts right) or dividend/quotient (shifts left)
  // r_mc : multiplicand (shifts left) or divisor (static)
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_sh;
  logic [WIDTH-1:0] r_mc;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_div;

  logic [WIDTH:0]   w_rs;
  logic             w_ge;

  always_comb begin
    w_rs     = {r_acc, r_sh[WIDTH-1]};
    w_ge     = (w_rs >= {1'b0, r_mc});
    acc_next = r_acc;
    sh_next  = r_sh;
    if (r_div) begin
      acc_next = w_ge ? WIDTH'(w_rs - {1'b0, r_mc}) : w_rs[WIDTH-1:0];
      sh_next  = {r_sh[WIDTH-2:0], w_ge};
    end else begin
      acc_next = r_sh[0] ? (r_acc + r_mc) : r_acc;
      sh_next  = r_sh >> 1;
    end
  end

  // done flags the step whose results the caller should capture
  assign done = r_busy && (r_cnt == C_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc  <= '0;
      r_sh   <= '0;
      r_mc   <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_div  <= 1'b0;
    end else if (start) begin
      r_acc  <= '0;
      r_sh   <= div_mode ? a : b;
      r_mc   <= div_mode ? b : a;
      r_cnt  <= '0;
      r_busy <= 1'b1;
      r_div  <= div_mode;
    end else if (r_busy) begin
      r_acc <= acc_next;
      r_sh  <= sh_next;
      if (!r_div) begin
        r_mc <= r_mc << 1;
      end
      if (r_cnt != C_MAX) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (done) begin
        r_busy <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_seq_mdu.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_mdu
// Description : Multi-cycle ALU with iterative MUL/DIVU/REMU, valid/ready
//               handshakes on both sides and a registered result.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq_mdu
  import alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       Operation,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             Overflow,
  output logic             Zero
);

  state_t           r_state;
  state_t           w_state_next;
  logic             r_rem;

  logic             w_accept;
  logic             w_start;
  logic             w_div_mode;
  logic             w_load_alu;
  logic             w_iter_done;
  logic [WIDTH-1:0] w_acc_next;
  logic [WIDTH-1:0] w_sh_next;

  logic             w_sub;
  logic [WIDTH-1:0] w_bx;
  logic [WIDTH-1:0] w_sum;
  logic             w_cout;
  logic             w_v;
  logic [WIDTH-1:0] w_alu_result;
  logic             w_alu_ovf;

  assign in_ready  = (r_state == IDLE) || ((r_state == DONE) && out_ready);
  assign out_valid = (r_state == DONE);
  assign w_accept  = in_valid && in_ready;
  assign Zero      = (Result == '0);

  always_comb begin
    w_sub           = (Operation == OP_SUB) || (Operation == OP_SLT);
    w_bx            = w_sub ? ~B : B;
    {w_cout, w_sum} = {1'b0, A} + {1'b0, w_bx} + {{WIDTH{1'b0}}, w_sub};
    // carry into MSB recovered from the sum bit, compared with carry out
    w_v             = (w_sum[WIDTH-1] ^ A[WIDTH-1] ^ w_bx[WIDTH-1]) ^ w_cout;
    w_alu_result    = '0;
    w_alu_ovf       = 1'b0;
    case (Operation)
      OP_AND:  w_alu_result = A & B;
      OP_OR:   w_alu_result = A | B;
      OP_ADD:  begin w_alu_result = w_sum; w_alu_ovf = w_v; end
      OP_SUB:  begin w_alu_result = w_sum; w_alu_ovf = w_v; end
      OP_SLT:  w_alu_result = {{(WIDTH-1){1'b0}}, w_sum[WIDTH-1] ^ w_v};
      OP_NOR:  w_alu_result = ~(A | B);
      OP_DIVU: w_alu_result = '1;
      OP_REMU: w_alu_result = A;
      default: w_alu_result = '0;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_div_mode   = 1'b0;
    w_load_alu   = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if ((r_state == DONE) && out_ready) begin
          w_state_next = IDLE;
        end
        if (w_accept) begin
          if (Operation == OP_MUL) begin
            w_start      = 1'b1;
            w_state_next = MUL;
          end else if (is_multicycle(Operation) && (B != '0)) begin
            w_start      = 1'b1;
            w_div_mode   = 1'b1;
            w_state_next = DIV;
          end else begin
            w_load_alu   = 1'b1;
            w_state_next = DONE;
          end
        end
      end
      MUL, DIV: begin
        if (w_iter_done) begin
          w_state_next = DONE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_rem    <= 1'b0;
      Result   <= '0;
      Overflow <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_rem <= (Operation == OP_REMU);
      end
      if (w_load_alu) begin
        Result   <= w_alu_result;
        Overflow <= w_alu_ovf;
      end else if (w_iter_done && ((r_state == MUL) || (r_state == DIV))) begin
        Result   <= ((r_state == DIV) && !r_rem) ? w_sh_next : w_acc_next;
        Overflow <= 1'b0;
      end
    end
  end

  alu_iter_unit #(
    .WIDTH(WIDTH)
  ) u_iter (
    .clk      (clk),
    .reset    (reset),
    .start    (w_start),
    .div_mode (w_div_mode),
    .a        (A),
    .b        (B),
    .done     (w_iter_done),
    .acc_next (w_acc_next),
    .sh_next  (w_sh_next)
  );

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_mdu.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_seq_mdu
// Description : Scoreboard bench for alu_seq_mdu at WIDTH 64 and WIDTH 8.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq_mdu;

  localparam logic [3:0] T_AND = 4'b0000, T_OR = 4'b0001, T_ADD = 4'b0010,
                         T_SUB = 4'b0110, T_SLT = 4'b0111, T_NOR = 4'b1100,
                         T_MUL = 4'b1000, T_DIVU = 4'b1001, T_REMU = 4'b1010;

  localparam logic [3:0]  ALU_OPS [10] = '{T_ADD, T_SUB, T_SLT, T_SLT, T_AND, T_OR, T_NOR, T_SUB, 4'b0011, T_ADD};
  localparam logic [63:0] ALU_A   [10] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd5, '1, 64'd1, 64'hF0F0_F0F0_F0F0_F0F0,
                                           64'd1, 64'd0, 64'h8000_0000_0000_0000, 64'd5, '1};
  localparam logic [63:0] ALU_B   [10] = '{64'd1, 64'd5, 64'd1, '1, 64'hFF00_FF00_FF00_FF00,
                                           64'd2, 64'd0, 64'd1, 64'd6, 64'd1};
  localparam logic [3:0]  DIV_OPS [6]  = '{T_DIVU, T_REMU, T_DIVU, T_REMU, T_DIVU, T_REMU};
  localparam logic [63:0] DIV_A   [6]  = '{64'd100, 64'd100, 64'd9, 64'd9, '1, 64'h8000_0000_0000_0001};
  localparam logic [63:0] DIV_B   [6]  = '{64'd7, 64'd7, 64'd0, 64'd0, 64'd3, 64'h0000_0000_FFFF_FFFF};
  localparam logic [63:0] MUL_A   [3]  = '{64'hFFFF_FFFF, '1, 64'h1234_5678_9ABC_DEF0};
  localparam logic [63:0] MUL_B   [3]  = '{64'hFFFF_FFFF, 64'd2, 64'h0FED_CBA9_8765_4321};

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, out_valid, out_ready, Overflow, Zero;
  logic [63:0] A, B, Result;
  logic [3:0]  Operation;
  logic        in_valid8, in_ready8, out_valid8, out_ready8, Overflow8, Zero8;
  logic [7:0]  A8, B8, Result8;
  logic [3:0]  Operation8;

  typedef struct {
    logic [63:0] res;
    logic        ovf;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  alu_seq_mdu #(.WIDTH(64)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Operation(Operation), .out_valid(out_valid),
    .out_ready(out_ready), .Result(Result), .Overflow(Overflow), .Zero(Zero)
  );

  alu_seq_mdu #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
    .A(A8), .B(B8), .Operation(Operation8), .out_valid(out_valid8),
    .out_ready(out_ready8), .Result(Result8), .Overflow(Overflow8), .Zero(Zero8)
  );

  function automatic exp_t model(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    exp_t e;
    e.res = 64'd0;
    e.ovf = 1'b0;
    e.lat = 1;
    case (op)
      T_AND: e.res = a & b;
      T_OR:  e.res = a | b;
      T_NOR: e.res = ~(a | b);
      T_ADD: begin
        e.res = a + b;
        e.ovf = (a[63] == b[63]) && (e.res[63] != a[63]);
      end
      T_SUB: begin
        e.res = a - b;
        e.ovf = (a[63] != b[63]) && (e.res[63] != a[63]);
      end
      T_SLT: e.res = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
      T_MUL: begin e.res = a * b; e.lat = 65; end
      T_DIVU: begin
        e.res = (b == 0) ? '1 : a / b;
        e.lat = (b == 0) ? 1 : 65;
      end
      T_REMU: begin
        e.res = (b == 0) ? a : a % b;
        e.lat = (b == 0) ? 1 : 65;
      end
      default: e.res = 64'd0;
    endcase
    return e;
  endfunction

  // Presents one request and waits (bounded) for out_valid; noise keeps
  // in_valid high with other operands while the DUT is busy.
  task automatic issue(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                       input bit noise, output int lat, output bit rdy_seen);
    @(negedge clk);
    Operation = op; A = a; B = b; in_valid = 1'b1; out_ready = 1'b0;
    lat = 0; rdy_seen = 1'b0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (noise) begin A = ~a; B = a; Operation = T_ADD; end
      else in_valid = 1'b0;
      if (!out_valid && in_ready) rdy_seen = 1'b1;
    end while (!out_valid && lat < 200);
    in_valid = 1'b0;
  endtask

  task automatic issue8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, output int lat);
    @(negedge clk);
    Operation8 = op; A8 = a; B8 = b; in_valid8 = 1'b1; out_ready8 = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      in_valid8 = 1'b0;
    end while (!out_valid8 && lat < 200);
  endtask

  task automatic consume();
    @(negedge clk); out_ready = 1'b1; out_ready8 = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0; out_ready8 = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    total += 5;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    if (Result !== 64'd0) begin bad++; $display("FAIL reset_result: got %h want 0", Result); end
    if (Zero !== 1'b1) begin bad++; $display("FAIL reset_zero: got %b want 1", Zero); end
    if (Overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow: got %b want 0", Overflow); end
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    total += 2;
    if (out_valid8 !== 1'b0) begin bad++; $display("FAIL reset8_out_valid: got %b want 0", out_valid8); end
    if (Zero8 !== 1'b1) begin bad++; $display("FAIL reset8_zero: got %b want 1", Zero8); end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_alu();
    int lat; bit rs; exp_t e;
    for (int i = 0; i < 10; i++) begin
      sb.push_back(model(ALU_OPS[i], ALU_A[i], ALU_B[i]));
      issue(ALU_OPS[i], ALU_A[i], ALU_B[i], 1'b0, lat, rs);
      e = sb.pop_front();
      total += 4;
      if (Result !== e.res) begin bad++; $display("FAIL alu%0d_result: got %h want %h", i, Result, e.res); end
      if (Overflow !== e.ovf) begin bad++; $display("FAIL alu%0d_overflow: got %b want %b", i, Overflow, e.ovf); end
      if (Zero !== (e.res == 64'd0)) begin bad++; $display("FAIL alu%0d_zero: got %b want %b", i, Zero, e.res == 64'd0); end
      if (lat != e.lat) begin bad++; $display("FAIL alu%0d_latency: got %0d want %0d", i, lat, e.lat); end
      consume();
    end
  endtask

  task automatic test_mul();
    int lat; bit rs; exp_t e;
    for (int i = 0; i < 3; i++) begin
      sb.push_back(model(T_MUL, MUL_A[i], MUL_B[i]));
      issue(T_MUL, MUL_A[i], MUL_B[i], (i == 0), lat, rs);
      e = sb.pop_front();
      total += 4;
      if (Result !== e.res) begin bad++; $display("FAIL mul%0d_result: got %h want %h", i, Result, e.res); end
      if (Overflow !== 1'b0) begin bad++; $display("FAIL mul%0d_overflow: got %b want 0", i, Overflow); end
      if (lat != e.lat) begin bad++; $display("FAIL mul%0d_latency: got %0d want %0d", i, lat, e.lat); end
      if (rs !== 1'b0) begin bad++; $display("FAIL mul%0d_in_ready_busy: got %b want 0", i, rs); end
      consume();
    end
  endtask

  task automatic test_div();
    int lat; bit rs; exp_t e;
    for (int i = 0; i < 6; i++) begin
      sb.push_back(model(DIV_OPS[i], DIV_A[i], DIV_B[i]));
      issue(DIV_OPS[i], DIV_A[i], DIV_B[i], (i == 1), lat, rs);
      e = sb.pop_front();
      total += 3;
      if (Result !== e.res) begin bad++; $display("FAIL div%0d_result: got %h want %h", i, Result, e.res); end
      if (lat != e.lat) begin bad++; $display("FAIL div%0d_latency: got %0d want %0d", i, lat, e.lat); end
      if (rs !== 1'b0) begin bad++; $display("FAIL div%0d_in_ready_busy: got %b want 0", i, rs); end
      consume();
    end
  endtask

  task automatic test_reset_mid_div();
    int lat; bit rs; exp_t e;
    @(negedge clk);
    Operation = T_DIVU; A = 64'd1000; B = 64'd3; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (29) @(posedge clk);
    #1;
    total += 2;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL middiv_out_valid: got %b want 0", out_valid); end
    if (in_ready !== 1'b0) begin bad++; $display("FAIL middiv_in_ready: got %b want 0", in_ready); end
    #1; reset = 1'b1; #1;
    total += 4;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_div_out_valid: got %b want 0", out_valid); end
    if (Result !== 64'd0) begin bad++; $display("FAIL rst_div_result: got %h want 0", Result); end
    if (Zero !== 1'b1) begin bad++; $display("FAIL rst_div_zero: got %b want 1", Zero); end
    if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_div_in_ready: got %b want 1", in_ready); end
    @(negedge clk); reset = 1'b0;
    sb.push_back(model(T_ADD, 64'd5, 64'd7));
    issue(T_ADD, 64'd5, 64'd7, 1'b0, lat, rs);
    e = sb.pop_front();
    total += 2;
    if (Result !== e.res) begin bad++; $display("FAIL post_rst_add: got %h want %h", Result, e.res); end
    if (lat != e.lat) begin bad++; $display("FAIL post_rst_latency: got %0d want %0d", lat, e.lat); end
    consume();
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [63:0] held;
    held = 64'd0;
    @(negedge clk); out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      A = 64'(i * 1000 + 1); B = 64'(i * 3); Operation = T_ADD; in_valid = 1'b1;
      sb.push_back(model(T_ADD, A, B));
      @(posedge clk); #1;
      e = sb.pop_front();
      held = e.res;
      total += 2;
      if (out_valid !== 1'b1) begin bad++; $display("FAIL b2b%0d_out_valid: got %b want 1", i, out_valid); end
      if (Result !== e.res) begin bad++; $display("FAIL b2b%0d_result: got %h want %h", i, Result, e.res); end
      @(negedge clk);
    end
    out_ready = 1'b0; A = 64'hDEAD; B = 64'hBEEF; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total += 3;
      if (Result !== held) begin bad++; $display("FAIL stall%0d_result: got %h want %h", i, Result, held); end
      if (in_ready !== 1'b0) begin bad++; $display("FAIL stall%0d_in_ready: got %b want 0", i, in_ready); end
      if (out_valid !== 1'b1) begin bad++; $display("FAIL stall%0d_out_valid: got %b want 1", i, out_valid); end
    end
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    total += 1;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL drain_out_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_width8();
    int lat; exp_t e;
    logic [3:0] ops [4];
    logic [7:0] av [4];
    logic [7:0] bv [4];
    ops = '{T_MUL, T_DIVU, T_REMU, T_ADD};
    av  = '{8'd15, 8'd255, 8'd255, 8'h7F};
    bv  = '{8'd17, 8'd16, 8'd16, 8'h01};
    sb.push_back('{res: 64'hFF, ovf: 1'b0, lat: 9});
    sb.push_back('{res: 64'h0F, ovf: 1'b0, lat: 9});
    sb.push_back('{res: 64'h0F, ovf: 1'b0, lat: 9});
    sb.push_back('{res: 64'h80, ovf: 1'b1, lat: 1});
    for (int i = 0; i < 4; i++) begin
      issue8(ops[i], av[i], bv[i], lat);
      e = sb.pop_front();
      total += 3;
      if (Result8 !== e.res[7:0]) begin bad++; $display("FAIL w8_%0d_result: got %h want %h", i, Result8, e.res[7:0]); end
      if (Overflow8 !== e.ovf) begin bad++; $display("FAIL w8_%0d_overflow: got %b want %b", i, Overflow8, e.ovf); end
      if (lat != e.lat) begin bad++; $display("FAIL w8_%0d_latency: got %0d want %0d", i, lat, e.lat); end
      consume();
    end
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0; Operation = '0;
    in_valid8 = 1'b0; out_ready8 = 1'b0; A8 = '0; B8 = '0; Operation8 = '0;
    test_reset();
    test_alu();
    test_mul();
    test_div();
    test_reset_mid_div();
    test_back_to_back();
    test_width8();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1);
  end

endmodule
`default_nettype wire
